// File: rtl/pipe_trace_buffer_pkg.sv
// trace_pkg: shared definitions for the pipeline trace buffer.
//   trace_state_e - capture FSM encoding, also driven on the state debug port
//   trace_mode_e  - access filter selection
//   entry_width() - width of one stored trace entry {pc, addr, data, rw}
//   mode_pass()   - does an access of the given direction pass the filter
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_FROZEN  = 2'b11
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_ALL    = 2'b00,
    MODE_WRITES = 2'b01,
    MODE_READS  = 2'b10,
    MODE_NONE   = 2'b11
  } trace_mode_e;

  localparam int DROP_W = 16;

  function automatic int entry_width(input int xlen);
    return 3 * xlen + 1;
  endfunction

  // rw = 1 marks a write access.
  function automatic logic mode_pass(input logic [1:0] mode, input logic rw);
    logic pass;
    case (trace_mode_e'(mode))
      MODE_ALL:    pass = 1'b1;
      MODE_WRITES: pass = rw;
      MODE_READS:  pass = ~rw;
      default:     pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// pipe_trace_buffer_if: memory-stage observation bus plus the drain port.
//   m_valid/m_pc/m_addr/m_rw/m_wdata/m_rdata - access seen in the memory stage
//   rd_valid/rd_ready/rd_data                - drain of the oldest trace entry
// Drain handshake: the buffer raises rd_valid whenever it holds an entry and
// shows the oldest one on rd_data; an entry is consumed on every rising clock
// edge where rd_valid and rd_ready are both 1. rd_valid never waits on
// rd_ready, and rd_data is held while stalled unless the buffer is full in
// wrap mode and a new entry overwrites the oldest.
// master = the side driving the pipeline and consuming entries; slave = buffer.
interface pipe_trace_buffer_if #(
  parameter int XLEN = 32
);
  import trace_pkg::*;

  localparam int EW = entry_width(XLEN);

  logic            m_valid;
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_addr;
  logic            m_rw;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] m_rdata;

  logic            rd_valid;
  logic            rd_ready;
  logic [EW-1:0]   rd_data;

  modport master (
    output m_valid, m_pc, m_addr, m_rw, m_wdata, m_rdata, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  m_valid, m_pc, m_addr, m_rw, m_wdata, m_rdata, rd_ready,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/pipe_trace_buffer_fifo.sv
// trace_fifo: circular entry store with optional overwrite of the oldest entry.
//   push/din      - append din (ignored when full, no pop and wrap=0)
//   wrap          - when full, a push without a pop evicts the oldest entry
//   pop_req       - consume the oldest entry if one is present
//   valid/dout    - an entry is present / the oldest entry
//   count/full    - occupancy, 0..DEPTH
//   dropped       - entries lost to overwrite, saturating
// Storage is not reset; only pointers and counters are.
module trace_fifo #(
  parameter int W     = 97,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          wrap,
  input  logic          pop_req,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic [15:0]   dropped
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   dropped_q, dropped_d;
  logic          pop;
  logic          push_ok;
  logic          overwrite;

  always_comb begin
    valid     = (count_q != '0);
    full      = (count_q == FULL_CNT);
    pop       = valid & pop_req;
    // A pop frees the slot the push needs, so a full buffer still accepts.
    push_ok   = push & (~full | pop | wrap);
    // Eviction only when nothing leaves through the drain port this cycle.
    overwrite = push & full & ~pop & wrap;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;

    // Pointers are exactly AW bits, so increments wrap modulo DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop | overwrite) rd_ptr_d = rd_ptr_q + AW'(1);

    if (push_ok & ~pop & ~overwrite) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop & ~push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end

    if (overwrite && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign dropped = dropped_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: captures memory-stage accesses into a drainable buffer.
//   clk, rst             - clock, synchronous active-high reset
//   enable               - arms capture; low returns the FSM to IDLE
//   mode                 - access filter (all / writes / reads / none)
//   wrap                 - when full: 1 overwrite oldest, 0 freeze
//   trig_en/addr/mask    - address trigger that starts capture
//   bus (slave)          - observed accesses and the drain handshake
//   count, dropped       - occupancy and overwrite-loss counter
//   state                - FSM state (IDLE/ARMED/CAPTURE/FROZEN)
// A qualifying access is registered first and written into the buffer on
// the following edge, keeping the wide entry mux off the storage write path.
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  wrap,
  input  logic                  trig_en,
  input  logic [XLEN-1:0]       trig_addr,
  input  logic [XLEN-1:0]       trig_mask,
  pipe_trace_buffer_if.slave    bus,
  output logic [AW:0]           count,
  output logic [DROP_W-1:0]     dropped,
  output logic [1:0]            state
);

  localparam int EW = entry_width(XLEN);

  trace_state_e  state_q, state_d;
  logic          push_q, push_d;
  logic [EW-1:0] entry_q, entry_d;

  logic addr_hit;
  logic access_ok;
  logic trig_hit;
  logic qualify;
  logic fifo_full;

  always_comb begin
    addr_hit  = ((bus.m_addr & trig_mask) == (trig_addr & trig_mask));
    access_ok = enable & bus.m_valid & mode_pass(mode, bus.m_rw);
    // With the trigger disabled any access seen while ARMED counts as the
    // trigger, so it is stored just like an address hit.
    trig_hit  = (state_q == ST_ARMED) & access_ok & (~trig_en | addr_hit);
    qualify   = trig_hit | ((state_q == ST_CAPTURE) & access_ok);

    push_d  = qualify;
    entry_d = entry_q;
    if (qualify) begin
      entry_d = {bus.m_pc, bus.m_addr,
                 bus.m_rw ? bus.m_wdata : bus.m_rdata, bus.m_rw};
    end

    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARMED;
        ST_ARMED:   if (!trig_en || trig_hit) state_d = ST_CAPTURE;
        ST_CAPTURE: if (fifo_full && !wrap) state_d = ST_FROZEN;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
    end
  end

  // Payload needs no reset: it is only consumed when push_q is set.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .din     (entry_q),
    .wrap    (wrap),
    .pop_req (bus.rd_ready),
    .valid   (bus.rd_valid),
    .dout    (bus.rd_data),
    .count   (count),
    .full    (fifo_full),
    .dropped (dropped)
  );

  assign state = state_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
module tb_pipe_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int EW    = 3 * XLEN + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             enable;
  logic [1:0]       mode;
  logic             wrap;
  logic             trig_en;
  logic [XLEN-1:0]  trig_addr;
  logic [XLEN-1:0]  trig_mask;
  logic [AW:0]      count;
  logic [15:0]      dropped;
  logic [1:0]       state;

  pipe_trace_buffer_if #(.XLEN(XLEN)) bus ();

  pipe_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mode      (mode),
    .wrap      (wrap),
    .trig_en   (trig_en),
    .trig_addr (trig_addr),
    .trig_mask (trig_mask),
    .bus       (bus),
    .count     (count),
    .dropped   (dropped),
    .state     (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Buffer contents as a plain queue; the state is tracked by the rules of
  // the trace buffer (0 idle, 1 armed, 2 capture, 3 frozen).
  logic [EW-1:0] exp_q[$];
  logic          pend_v = 1'b0;
  logic [EW-1:0] pend_e;
  int            m_dropped = 0;
  int            m_state = 0;

  function automatic logic mode_allows(input logic [1:0] md, input logic rw);
    return (md == 2'd0) || (md == 2'd1 && rw) || (md == 2'd2 && !rw);
  endfunction

  function automatic logic [EW-1:0] make_entry(input logic [31:0] pc, input logic [31:0] addr,
                                               input logic rw, input logic [31:0] wd,
                                               input logic [31:0] rd);
    logic [31:0] d;
    d = rw ? wd : rd;
    return {pc, addr, d, rw};
  endfunction

  task automatic model_step();
    logic acc, hit, qual;
    int   nxt;
    if (rst) begin
      exp_q.delete();
      pend_v    = 1'b0;
      m_dropped = 0;
      m_state   = 0;
      return;
    end
    acc  = enable && bus.m_valid && mode_allows(mode, bus.m_rw);
    hit  = acc && (!trig_en || (((bus.m_addr ^ trig_addr) & trig_mask) == 32'd0));
    qual = (m_state == 1 && hit) || (m_state == 2 && acc);
    nxt  = m_state;
    if (!enable) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1 && (!trig_en || hit)) nxt = 2;
    else if (m_state == 2 && exp_q.size() == DEPTH && !wrap) nxt = 3;
    // Drain first, then land the access registered on the previous cycle.
    if (exp_q.size() != 0 && bus.rd_ready) void'(exp_q.pop_front());
    if (pend_v) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(pend_e);
      end else if (wrap) begin
        void'(exp_q.pop_front());
        exp_q.push_back(pend_e);
        if (m_dropped < 65535) m_dropped++;
      end
    end
    pend_v  = qual;
    pend_e  = make_entry(bus.m_pc, bus.m_addr, bus.m_rw, bus.m_wdata, bus.m_rdata);
    m_state = nxt;
  endtask

  task automatic compare_model();
    check("model_count", 128'(count), 128'(exp_q.size()));
    check("model_rd_valid", 128'(bus.rd_valid), 128'(exp_q.size() != 0));
    check("model_state", 128'(state), 128'(m_state));
    check("model_dropped", 128'(dropped), 128'(m_dropped));
    if (exp_q.size() != 0) check("model_rd_data", 128'(bus.rd_data), 128'(exp_q[0]));
  endtask

  // One clock: model sees the inputs presented for this edge, DUT outputs
  // are sampled 1ns after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_access(input logic [31:0] pc, input logic [31:0] addr, input logic rw);
    bus.m_valid = 1'b1;
    bus.m_pc    = pc;
    bus.m_addr  = addr;
    bus.m_rw    = rw;
    bus.m_wdata = 32'hA000_0000 | pc;
    bus.m_rdata = 32'hB000_0000 | pc;
  endtask

  task automatic access(input logic [31:0] pc, input logic [31:0] addr, input logic rw);
    set_access(pc, addr, rw);
    tick();
    bus.m_valid = 1'b0;
  endtask

  task automatic do_reset();
    enable       = 1'b0;
    bus.m_valid  = 1'b0;
    bus.rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Enable with trigger disabled: IDLE -> ARMED -> CAPTURE.
  task automatic arm_free();
    trig_en = 1'b0;
    enable  = 1'b1;
    tick();
    tick();
  endtask

  function automatic logic [31:0] pc_of(input logic [EW-1:0] e);
    return e[EW-1 -: 32];
  endfunction

  // ---------------- table-driven filter / trigger vectors ----------------
  typedef struct {
    logic [1:0]  mode;
    logic        te;
    logic [31:0] ta;
    logic [31:0] tm;
    logic [31:0] addr;
    logic        rw;
    logic [AW:0] exp_count;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; wrap = 1'b1;
    trig_en = 1'b0; trig_addr = '0; trig_mask = '0;
    bus.m_valid = 1'b0; bus.m_pc = '0; bus.m_addr = '0; bus.m_rw = 1'b0;
    bus.m_wdata = '0; bus.m_rdata = '0; bus.rd_ready = 1'b0;

    vecs[0]  = '{2'd0, 1'b0, 32'h0,   32'h0,        32'h10,  1'b0, 3'd1, 2'd2};
    vecs[1]  = '{2'd0, 1'b0, 32'h0,   32'h0,        32'h10,  1'b1, 3'd1, 2'd2};
    vecs[2]  = '{2'd1, 1'b0, 32'h0,   32'h0,        32'h10,  1'b0, 3'd0, 2'd2};
    vecs[3]  = '{2'd1, 1'b0, 32'h0,   32'h0,        32'h10,  1'b1, 3'd1, 2'd2};
    vecs[4]  = '{2'd2, 1'b0, 32'h0,   32'h0,        32'h10,  1'b0, 3'd1, 2'd2};
    vecs[5]  = '{2'd2, 1'b0, 32'h0,   32'h0,        32'h10,  1'b1, 3'd0, 2'd2};
    vecs[6]  = '{2'd3, 1'b0, 32'h0,   32'h0,        32'h10,  1'b1, 3'd0, 2'd2};
    vecs[7]  = '{2'd0, 1'b1, 32'h200, 32'hFFFFFF00, 32'h2AC, 1'b0, 3'd1, 2'd2};
    vecs[8]  = '{2'd0, 1'b1, 32'h200, 32'hFFFFFF00, 32'h3AC, 1'b0, 3'd0, 2'd1};
    vecs[9]  = '{2'd0, 1'b1, 32'h200, 32'h0,        32'h9F0, 1'b1, 3'd1, 2'd2};
    vecs[10] = '{2'd2, 1'b1, 32'h200, 32'hFFFFFF00, 32'h200, 1'b1, 3'd0, 2'd1};

    // Reset state
    do_reset();
    check("reset_state", 128'(state), 128'(2'd0));
    check("reset_count", 128'(count), 128'(0));
    check("reset_rd_valid", 128'(bus.rd_valid), 128'(1'b0));
    check("reset_dropped", 128'(dropped), 128'(0));

    for (int i = 0; i < 11; i++) begin
      do_reset();
      mode      = vecs[i].mode;
      trig_en   = vecs[i].te;
      trig_addr = vecs[i].ta;
      trig_mask = vecs[i].tm;
      enable    = 1'b1;
      tick();
      if (!vecs[i].te) tick();
      access(32'h40, vecs[i].addr, vecs[i].rw);
      tick();
      check($sformatf("vec%0d_count", i), 128'(count), 128'(vecs[i].exp_count));
      check($sformatf("vec%0d_state", i), 128'(state), 128'(vecs[i].exp_state));
    end

    // Three accesses, all modes, drained in order with data select by rw
    do_reset();
    mode = 2'd0; wrap = 1'b1;
    arm_free();
    access(32'h0, 32'h1000, 1'b1);
    access(32'h4, 32'h1004, 1'b0);
    access(32'h8, 32'h1008, 1'b1);
    tick();
    check("seq3_count", 128'(count), 128'(3));
    check("seq3_e0", 128'(bus.rd_data), 128'({32'h0, 32'h1000, 32'hA000_0000, 1'b1}));
    bus.rd_ready = 1'b1;
    tick();
    check("seq3_e1", 128'(bus.rd_data), 128'({32'h4, 32'h1004, 32'hB000_0004, 1'b0}));
    tick();
    check("seq3_e2", 128'(bus.rd_data), 128'({32'h8, 32'h1008, 32'hA000_0008, 1'b1}));
    tick();
    check("seq3_empty", 128'(bus.rd_valid), 128'(1'b0));
    bus.rd_ready = 1'b0;

    // Address trigger with write-only filter
    do_reset();
    mode = 2'd1; trig_en = 1'b1; trig_addr = 32'h100; trig_mask = 32'hFFFF_FFF0;
    enable = 1'b1;
    tick();
    access(32'h20, 32'h40, 1'b1);
    check("trig_miss_state", 128'(state), 128'(2'd1));
    access(32'h24, 32'h100, 1'b0);
    check("trig_read_state", 128'(state), 128'(2'd1));
    access(32'h28, 32'h104, 1'b1);
    check("trig_hit_state", 128'(state), 128'(2'd2));
    tick();
    check("trig_count", 128'(count), 128'(1));
    check("trig_addr", 128'(bus.rd_data[64:33]), 128'(32'h104));

    // Wrap overwrite, then simultaneous push and pop while full
    do_reset();
    mode = 2'd0; wrap = 1'b1;
    arm_free();
    for (int i = 0; i < 6; i++) access(32'(4 * i), 32'h2000, 1'b1);
    tick();
    check("wrap_count", 128'(count), 128'(4));
    check("wrap_dropped", 128'(dropped), 128'(2));
    check("wrap_oldest_pc", 128'(pc_of(bus.rd_data)), 128'(32'h8));
    access(32'h18, 32'h2000, 1'b0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("pushpop_count", 128'(count), 128'(4));
    check("pushpop_dropped", 128'(dropped), 128'(2));
    check("pushpop_oldest_pc", 128'(pc_of(bus.rd_data)), 128'(32'hC));

    // Freeze when full without wrap, then release with enable=0
    do_reset();
    wrap = 1'b0;
    arm_free();
    for (int i = 0; i < 6; i++) access(32'(4 * i), 32'h3000, 1'b0);
    tick();
    check("freeze_state", 128'(state), 128'(2'd3));
    check("freeze_count", 128'(count), 128'(4));
    check("freeze_dropped", 128'(dropped), 128'(0));
    check("freeze_oldest_pc", 128'(pc_of(bus.rd_data)), 128'(32'h0));
    enable = 1'b0;
    tick();
    check("release_state", 128'(state), 128'(2'd0));
    check("release_count", 128'(count), 128'(4));

    // Reset mid-capture with a push in flight
    do_reset();
    wrap = 1'b1;
    arm_free();
    for (int i = 0; i < 3; i++) access(32'(4 * i), 32'h4000, 1'b1);
    tick();
    check("midrst_pre_count", 128'(count), 128'(3));
    access(32'hC, 32'h4000, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", 128'(count), 128'(0));
    check("midrst_rd_valid", 128'(bus.rd_valid), 128'(1'b0));
    check("midrst_state", 128'(state), 128'(2'd0));
    tick();
    check("midrst_lost_push", 128'(count), 128'(0));

    // Randomized traffic against the model
    do_reset();
    for (int seg = 0; seg < 15; seg++) begin
      wrap      = 1'($urandom_range(0, 1));
      trig_en   = 1'($urandom_range(0, 1));
      trig_addr = $urandom;
      trig_mask = 32'h0000_000F;
      mode      = 2'($urandom_range(0, 3));
      for (int c = 0; c < 200; c++) begin
        rst    = ($urandom_range(0, 299) == 0);
        enable = ($urandom_range(0, 99) < 96);
        if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
        bus.m_valid  = ($urandom_range(0, 9) < 6);
        bus.m_rw     = 1'($urandom_range(0, 1));
        bus.m_pc     = $urandom;
        bus.m_addr   = trig_addr ^ 32'($urandom_range(0, 31));
        bus.m_wdata  = $urandom;
        bus.m_rdata  = $urandom;
        bus.rd_ready = ($urandom_range(0, 9) < 3);
        tick();
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
